// File: rtl/any1_pkg.sv
// Shared any1 types: the sDecode record, stream number and decode-queue sizing.
package any1_pkg;

    localparam int DECQ_DEPTH_DEF = 8;

    typedef logic [$clog2(DECQ_DEPTH_DEF)-1:0] tDecqPtr;

    typedef logic [3:0] tStream;

    typedef struct packed {
        logic [31:0] ip;
        logic [31:0] ir;
        tStream      Stream;
        logic        Stream_inc;
        logic        ui;
        logic [5:0]  Rt;
        logic        rfwr;
    } sDecode;

endpackage

// File: rtl/any1_decq_stream_filter.sv
// Tracks the currently valid instruction stream and qualifies decode pushes against it.
module any1_decq_stream_filter
    import any1_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  logic   flush_i,
    input  tStream flush_stream_i,
    input  tStream stream_i,
    input  logic   stream_inc_i,
    input  logic   push_acc_i,
    output logic   push_ok_o
);

    tStream last_stream_q;
    tStream last_stream_d;

    always_comb begin
        push_ok_o     = push_i && (flush_i ? (stream_i == flush_stream_i)
                                           : (stream_i == last_stream_q));
        last_stream_d = last_stream_q;
        if (flush_i)
            last_stream_d = flush_stream_i;
        // A JAL/BAL opens the next stream for the record that follows it.
        if (push_acc_i && stream_inc_i)
            last_stream_d = last_stream_d + tStream'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            last_stream_q <= '0;
        else
            last_stream_q <= last_stream_d;
    end

endmodule

// File: rtl/any1_decode_queue.sv
// Elastic decode-to-issue queue with flush stream filtering.
// Optional same-cycle bypass of an empty queue: define ANY1_DECQ_BYPASS_EN.
module any1_decode_queue
    import any1_pkg::*;
#(
    parameter int DEPTH        = DECQ_DEPTH_DEF,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  sDecode                     dec_i,
    output logic                       full_o,
    output logic                       almost_full_o,
    input  logic                       pop_i,
    output logic                       valid_o,
    output sDecode                     head_o,
    input  logic                       flush_i,
    input  tStream                     flush_stream_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       ovf_o
);

    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] MARGIN_C = CW'(AFULL_MARGIN);

    // Handshake: push_i is a valid with full_o as its back-pressure; valid_o/pop_i
    // transfer the head record on any edge where both are high and no flush is active.

    sDecode          mem_q [DEPTH];
    sDecode          mem_d [DEPTH];
    sDecode          head_q, head_d;
    logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            push_ok, push_acc, pop_acc, byp_pop, wr_en;

    any1_decq_stream_filter u_filter (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .push_i         (push_i),
        .flush_i        (flush_i),
        .flush_stream_i (flush_stream_i),
        .stream_i       (dec_i.Stream),
        .stream_inc_i   (dec_i.Stream_inc),
        .push_acc_i     (push_acc),
        .push_ok_o      (push_ok)
    );

    always_comb begin
        pop_acc  = pop_i && (count_q != '0) && !flush_i;
        byp_pop  = 1'b0;
`ifdef ANY1_DECQ_BYPASS_EN
        byp_pop  = pop_i && !flush_i && (count_q == '0) && push_ok;
`endif
        // A flush empties the queue, so its qualified push always fits.
        push_acc = push_ok && ((count_q != DEPTH_C) || pop_acc || flush_i);
        wr_en    = push_acc && !byp_pop;

        rd_d     = rd_q;
        wr_d     = wr_q;
        count_d  = count_q;
        ovf_d    = ovf_q || (push_ok && !push_acc);

        if (flush_i) begin
            rd_d    = wr_q;
            wr_d    = wr_en ? wr_q + PW'(1) : wr_q;
            count_d = wr_en ? CW'(1) : '0;
        end else begin
            if (pop_acc)
                rd_d = rd_q + PW'(1);
            if (wr_en)
                wr_d = wr_q + PW'(1);
            case ({wr_en, pop_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        for (int i = 0; i < DEPTH; i++)
            mem_d[i] = mem_q[i];
        if (wr_en)
            mem_d[wr_q] = dec_i;

        head_d = '0;
        if (count_d != '0)
            head_d = mem_d[rd_d];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            head_q  <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            head_q  <= head_d;
        end
    end

    // Storage needs no reset; only entries behind a valid count are ever read.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= mem_d[i];
    end

    assign full_o        = (count_q == DEPTH_C);
    assign almost_full_o = ((DEPTH_C - count_q) <= MARGIN_C);
    assign count_o       = count_q;
    assign ovf_o         = ovf_q;

`ifdef ANY1_DECQ_BYPASS_EN
    assign valid_o = (count_q != '0) || push_acc;
    assign head_o  = ((count_q == '0) && push_acc) ? dec_i : head_q;
`else
    assign valid_o = (count_q != '0);
    assign head_o  = head_q;
`endif

endmodule

// File: tb/tb_any1_decode_queue.sv
// Self-checking bench for any1_decode_queue: directed scenarios plus a random push/pop phase.
module tb_any1_decode_queue;
  import any1_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         push_i = 1'b0;
  sDecode       dec_i = '0;
  logic         full_o, almost_full_o, valid_o, ovf_o;
  logic         pop_i = 1'b0;
  sDecode       head_o;
  logic         flush_i = 1'b0;
  tStream       flush_stream_i = '0;
  logic [3:0]   count_o;

  logic [31:0]  exp_q[$];
  int           n_checks = 0;
  int           n_fail = 0;

  any1_decode_queue #(.DEPTH(8), .AFULL_MARGIN(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .push_i(push_i), .dec_i(dec_i),
    .full_o(full_o), .almost_full_o(almost_full_o), .pop_i(pop_i),
    .valid_o(valid_o), .head_o(head_o), .flush_i(flush_i),
    .flush_stream_i(flush_stream_i), .count_o(count_o), .ovf_o(ovf_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver: apply inputs for one cycle, return #1 after the capturing edge
  task automatic step(input logic push, input logic [31:0] ip, input tStream st,
                      input logic inc, input logic pop, input logic flush, input tStream fst);
    push_i = push;
    dec_i = '0;
    dec_i.ip = ip;
    dec_i.Stream = st;
    dec_i.Stream_inc = inc;
    pop_i = pop;
    flush_i = flush;
    flush_stream_i = fst;
    @(posedge clk_i);
    #1;
    push_i = 1'b0;
    pop_i = 1'b0;
    flush_i = 1'b0;
  endtask

  // scoreboard: compare current head with the oldest expected record
  task automatic pop_chk();
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check_val("pop_on_empty_model", {31'd0, valid_o}, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_val("head_ip", head_o.ip, e);
    end
  endtask

  task automatic chk_count(input string tag);
    check_val(tag, 32'(count_o), 32'(exp_q.size()));
  endtask

  initial begin
    int sz;
    logic p, q, acc;
    logic [31:0] rip;

    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    check_val("rst_count", 32'(count_o), 0);
    check_val("rst_valid", {31'd0, valid_o}, 0);
    check_val("rst_full", {31'd0, full_o}, 0);
    check_val("rst_afull", {31'd0, almost_full_o}, 0);
    check_val("rst_ovf", {31'd0, ovf_o}, 0);
    check_val("rst_head", head_o.ip, 0);
    rst_ni = 1'b1;

    // fill
    for (int i = 0; i < 8; i++) begin
      step(1, 32'h100 + 32'(8 * i), 0, 0, 0, 0, 0);
      exp_q.push_back(32'h100 + 32'(8 * i));
      chk_count("fill_count");
      if (i == 4) check_val("afull_after5", {31'd0, almost_full_o}, 0);
      if (i == 5) check_val("afull_after6", {31'd0, almost_full_o}, 1);
      if (i == 6) check_val("full_after7", {31'd0, full_o}, 0);
    end
    check_val("full_after8", {31'd0, full_o}, 1);

    // overflow, then push+pop while full
    step(1, 32'h200, 0, 0, 0, 0, 0);
    check_val("ovf_count", 32'(count_o), 8);
    check_val("ovf_set", {31'd0, ovf_o}, 1);
    pop_chk();
    step(1, 32'h208, 0, 0, 1, 0, 0);
    exp_q.push_back(32'h208);
    check_val("full_pp_count", 32'(count_o), 8);
    check_val("full_pp_ovf", {31'd0, ovf_o}, 1);
    check_val("full_pp_head", head_o.ip, 32'h108);

    // drain
    while (exp_q.size() > 0) begin
      pop_chk();
      step(0, 0, 0, 0, 1, 0, 0);
    end
    check_val("drain_valid", {31'd0, valid_o}, 0);
    chk_count("drain_count");
    step(0, 0, 0, 0, 1, 0, 0);
    check_val("pop_empty_count", 32'(count_o), 0);

    // flush with qualified push
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h300 + 32'(8 * i), 0, 0, 0, 0, 0);
      exp_q.push_back(32'h300 + 32'(8 * i));
    end
    chk_count("preflush_count");
    step(1, 32'h400, 3, 0, 1, 1, 3);
    exp_q.delete();
    exp_q.push_back(32'h400);
    chk_count("flush_count");
    check_val("flush_head", head_o.ip, 32'h400);
    step(1, 32'h408, 2, 0, 0, 0, 0);
    chk_count("stale_stream_drop");

    // stream increment (also push+pop at count=1)
    pop_chk();
    step(1, 32'h410, 3, 1, 1, 0, 0);
    exp_q.push_back(32'h410);
    chk_count("jal_pp_count");
    step(1, 32'h418, 4, 0, 0, 0, 0);
    exp_q.push_back(32'h418);
    check_val("inc_count", 32'(count_o), 2);
    step(1, 32'h420, 3, 0, 0, 0, 0);
    check_val("old_stream_drop", 32'(count_o), 2);
    check_val("inc_head", head_o.ip, 32'h410);

    // reset mid-operation with a push in the reset cycle
    step(1, 32'h428, 4, 0, 0, 0, 0);
    step(1, 32'h430, 4, 0, 0, 0, 0);
    check_val("prerst_count", 32'(count_o), 4);
    rst_ni = 1'b0;
    step(1, 32'h600, 4, 0, 0, 0, 0);
    rst_ni = 1'b1;
    exp_q.delete();
    check_val("midrst_count", 32'(count_o), 0);
    check_val("midrst_valid", {31'd0, valid_o}, 0);
    check_val("midrst_ovf", {31'd0, ovf_o}, 0);
    step(1, 32'h610, 4, 0, 0, 0, 0);
    check_val("midrst_stream_drop", 32'(count_o), 0);
    step(1, 32'h700, 0, 0, 0, 0, 0);
    exp_q.push_back(32'h700);
    chk_count("laststream0_count");
    check_val("laststream0_head", head_o.ip, 32'h700);
    pop_chk();
    step(0, 0, 0, 0, 1, 0, 0);
    check_val("post_rst_valid", {31'd0, valid_o}, 0);

    // empty-queue push with pop: latency / bypass
    push_i = 1'b1;
    dec_i = '0;
    dec_i.ip = 32'h500;
    pop_i = 1'b1;
    #1;
`ifdef ANY1_DECQ_BYPASS_EN
    check_val("byp_valid", {31'd0, valid_o}, 1);
    check_val("byp_head", head_o.ip, 32'h500);
`else
    check_val("lat_valid_same", {31'd0, valid_o}, 0);
    exp_q.push_back(32'h500);
`endif
    @(posedge clk_i);
    #1;
    push_i = 1'b0;
    pop_i = 1'b0;
    chk_count("lat_count");
`ifndef ANY1_DECQ_BYPASS_EN
    check_val("lat_valid_next", {31'd0, valid_o}, 1);
    check_val("lat_head_next", head_o.ip, 32'h500);
`endif

    // random push/pop against the scoreboard
    for (int i = 0; i < 80; i++) begin
      p = 1'($urandom_range(0, 1));
      q = 1'($urandom_range(0, 1));
      rip = 32'h1000 + 32'(i * 4);
      sz = exp_q.size();
      acc = p && ((sz < 8) || (q && sz > 0));
      if (q && sz > 0) pop_chk();
      step(p, rip, 0, 0, q, 0, 0);
      if (acc) exp_q.push_back(rip);
      chk_count("rand_count");
    end
    while (exp_q.size() > 0) begin
      pop_chk();
      step(0, 0, 0, 0, 1, 0, 0);
    end
    check_val("final_valid", {31'd0, valid_o}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
